// File: rtl/material_system.sv
// rtl/material_system.sv - Station-level material handler: temperature check, drop and pickup sequencing
//
// Purpose:
//   Watches the station-detect trigger. Station and pickup events alternate.
//   On a station event it samples the XADC temperature word and flags whether
//   it is inside the accepted band. An in-band sample releases the carried
//   material. On a pickup event it lowers the servo for SERVO_HOLD cycles
//   with the electromagnet energized.
//
// Optional feature macro: TRIGGER_DEBOUNCE_EN
//   When defined, an event requires DEBOUNCE consecutive high cycles on trigger.
//
// Ports:
//   ACLK          in   system clock
//   ARESET        in   synchronous active-high reset
//   trigger       in   station/pickup detect (level)
//   digitalTemp   in   12-bit unsigned XADC temperature code
//   ready         in   XADC conversion valid
//   correct       out  last sampled temperature inside [TEMP_MIN, TEMP_MAX]
//   controlEM     out  electromagnet enable (1 = holding material)
//   controlServo  out  servo position (1 = lowered)

module material_system #(
  parameter int SCALE      = 68,
  parameter int TEMP_MIN   = 20 * SCALE,
  parameter int TEMP_MAX   = 35 * SCALE,
  parameter int SERVO_HOLD = 20,
  parameter int DEBOUNCE   = 3
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        trigger,
  input  logic [11:0] digitalTemp,
  input  logic        ready,
  output logic        correct,
  output logic        controlEM,
  output logic        controlServo
);

  localparam int          CW    = (SERVO_HOLD > 1) ? $clog2(SERVO_HOLD + 1) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(SERVO_HOLD - 1);
  localparam logic [11:0] T_MIN = 12'(TEMP_MIN);
  localparam logic [11:0] T_MAX = 12'(TEMP_MAX);

  typedef enum logic [2:0] {
    IDLE,
    MEASURE,
    TRAVEL,
    LOWER,
    RAISE
  } state_t;

  state_t        state;
  logic          trig_q;
  logic [CW-1:0] hold_cnt;
  logic          trig_event;
  logic          in_range;

  assign in_range = (digitalTemp >= T_MIN) && (digitalTemp <= T_MAX);

  always_ff @(posedge ACLK) begin
    if (ARESET) trig_q <= 1'b0;
    else        trig_q <= trigger;
  end

`ifdef TRIGGER_DEBOUNCE_EN
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE - 1);
  logic [7:0] db_cnt;

  // Counts consecutive high cycles and parks one past the firing count, so a
  // held trigger fires once and only a low level re-arms it.
  always_ff @(posedge ACLK) begin
    if (ARESET || !trigger) db_cnt <= 8'd0;
    else if (db_cnt <= DB_LAST) db_cnt <= db_cnt + 8'd1;
  end

  assign trig_event = trigger && (db_cnt == DB_LAST);
`else
  assign trig_event = trigger & ~trig_q;
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state        <= IDLE;
      correct      <= 1'b0;
      controlEM    <= 1'b0;
      controlServo <= 1'b0;
      hold_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trig_event) state <= MEASURE;
        end
        MEASURE: begin
          // The sample is whatever digitalTemp shows on the first ready edge.
          if (ready) begin
            correct <= in_range;
            if (in_range) controlEM <= 1'b0;
            state <= TRAVEL;
          end
        end
        TRAVEL: begin
          if (trig_event) begin
            hold_cnt <= '0;
            state    <= LOWER;
          end
        end
        LOWER: begin
          controlServo <= 1'b1;
          controlEM    <= 1'b1;
          hold_cnt     <= hold_cnt + 1'b1;
          if (hold_cnt == HOLD_LAST) state <= RAISE;
        end
        RAISE: begin
          controlServo <= 1'b0;
          hold_cnt     <= '0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_material_system.sv
// tb/tb_material_system.sv - Self-checking bench for material_system

module tb_material_system;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        trigger;
  logic [11:0] digitalTemp;
  logic        ready;
  logic        correct;
  logic        controlEM;
  logic        controlServo;

  int checks   = 0;
  int failures = 0;

  // Scoreboard of expected {correct, controlEM} after each station sample.
  logic [1:0] exp_q[$];
  logic       m_correct;
  logic       m_em;

  always #5 ACLK = ~ACLK;

  material_system dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .trigger(trigger),
    .digitalTemp(digitalTemp),
    .ready(ready),
    .correct(correct),
    .controlEM(controlEM),
    .controlServo(controlServo)
  );

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge ACLK);
  endtask

  task automatic push_station(input logic [11:0] t);
    logic in_band;
    in_band = (t >= 12'd1360) && (t <= 12'd2380);
    m_correct = in_band;
    if (in_band) m_em = 1'b0;
    exp_q.push_back({m_correct, m_em});
  endtask

  task automatic test_reset;
    ARESET = 1'b1; trigger = 1'b0; ready = 1'b1; digitalTemp = 12'd0;
    cycles(3);
    checks++;
    if ({correct, controlEM, controlServo} !== 3'b000) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=000", {correct, controlEM, controlServo});
    end
    ARESET = 1'b0;
    m_correct = 1'b0; m_em = 1'b0;
    cycles(2);
  endtask

  // Station event with ready already high: outputs update one edge after the event edge.
  task automatic test_station(input logic [11:0] t, input string name);
    logic [1:0] exp;
    digitalTemp = t;
    push_station(t);
    trigger = 1'b1;
    cycles(1);
    cycles(1);
    exp = exp_q.pop_front();
    checks++;
    if ({correct, controlEM} !== exp) begin
      failures++;
      $display("FAIL station_%s got={correct,em}=%b want=%b", name, {correct, controlEM}, exp);
    end
    cycles(3);
    trigger = 1'b0;
    cycles(25);
    checks++;
    if ({correct, controlEM, controlServo} !== {exp, 1'b0}) begin
      failures++;
      $display("FAIL station_hold_%s got=%b want=%b", name, {correct, controlEM, controlServo}, {exp, 1'b0});
    end
  endtask

  task automatic test_pickup(input string name);
    int high_cnt;
    int first_high;
    trigger = 1'b1;
    cycles(1);
    checks++;
    if (controlServo !== 1'b0) begin
      failures++;
      $display("FAIL pickup_early_%s got servo=%b want=0", name, controlServo);
    end
    high_cnt = 0; first_high = -1;
    for (int i = 1; i <= 30; i++) begin
      cycles(1);
      if (i == 5) trigger = 1'b0;
      if (controlServo === 1'b1) begin
        high_cnt++;
        if (first_high < 0) first_high = i;
      end
    end
    m_em = 1'b1;
    checks++;
    if (high_cnt != 20 || first_high != 1) begin
      failures++;
      $display("FAIL pickup_pulse_%s got high=%0d first=%0d want high=20 first=1", name, high_cnt, first_high);
    end
    checks++;
    if ({correct, controlEM, controlServo} !== {m_correct, m_em, 1'b0}) begin
      failures++;
      $display("FAIL pickup_after_%s got=%b want=%b", name, {correct, controlEM, controlServo}, {m_correct, m_em, 1'b0});
    end
  endtask

  task automatic test_ready_stall;
    logic [1:0] exp;
    logic [1:0] prev;
    int bad;
    prev = {correct, controlEM};
    ready = 1'b0;
    digitalTemp = 12'd2652;
    trigger = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      if (i == 4) trigger = 1'b0;
      if ({correct, controlEM} !== prev) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL ready_stall got %0d changed cycles want 0", bad);
    end
    digitalTemp = 12'd1700;
    ready = 1'b1;
    push_station(12'd1700);
    cycles(1);
    exp = exp_q.pop_front();
    checks++;
    if ({correct, controlEM} !== exp) begin
      failures++;
      $display("FAIL ready_release got=%b want=%b", {correct, controlEM}, exp);
    end
    cycles(5);
  endtask

  task automatic test_reset_mid_lower;
    int servo_seen;
    trigger = 1'b1;
    cycles(6);
    checks++;
    if (controlServo !== 1'b1) begin
      failures++;
      $display("FAIL lower_before_reset got servo=%b want=1", controlServo);
    end
    ARESET = 1'b1;
    cycles(1);
    checks++;
    if ({correct, controlEM, controlServo} !== 3'b000) begin
      failures++;
      $display("FAIL reset_mid_lower got=%b want=000", {correct, controlEM, controlServo});
    end
    ARESET = 1'b0;
    trigger = 1'b0;
    m_correct = 1'b0; m_em = 1'b0;
    cycles(3);
    // After reset the next trigger must be a station event: no servo motion.
    digitalTemp = 12'd2000;
    push_station(12'd2000);
    trigger = 1'b1;
    servo_seen = 0;
    for (int i = 0; i < 8; i++) begin
      cycles(1);
      if (controlServo === 1'b1) servo_seen++;
    end
    trigger = 1'b0;
    checks++;
    if (servo_seen != 0) begin
      failures++;
      $display("FAIL post_reset_station servo high %0d cycles want 0", servo_seen);
    end
    checks++;
    begin
      logic [1:0] exp;
      exp = exp_q.pop_front();
      if ({correct, controlEM} !== exp) begin
        failures++;
        $display("FAIL post_reset_sample got=%b want=%b", {correct, controlEM}, exp);
      end
    end
    cycles(5);
  endtask

  task automatic test_back_to_back;
    test_station(12'd1700, "25C");
    test_pickup("p1");
    test_station(12'd1020, "15C");
    test_pickup("p2");
    test_station(12'd2652, "39C");
    test_pickup("p3");
    test_station(12'd1360, "min");
    test_pickup("p4");
    test_station(12'd2380, "max");
    test_pickup("p5");
    test_station(12'd2381, "max_p1");
    test_pickup("p6");
    test_station(12'd1359, "min_m1");
    test_pickup("p7");
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_ready_stall;
    test_reset_mid_lower;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
